servo_ramp_driver: RTL and testbench
====================================

# servo_ramp_driver

Multi-channel continuous-rotation servo driver with per-channel slew-rate limiting and a valid/ready command port. Replaces the fixed two-servo driver with unit speed steps: any channel count and speed width, configurable frame and pulse timing, and target changes applied only at frame boundaries. It sits between the navigation controller, which supplies speed words, and the servo output pins.

## Interface
Parameters:
- CHANNELS, 2, number of servo outputs
- SPEED_W, 8, speed word width; neutral (stop) = 2^(SPEED_W-1)
- PERIOD_CYCLES, 1000000, PWM frame length in clocks (20 ms at 50 MHz)
- MIN_PULSE, 50000, pulse width in clocks at speed 0
- PULSE_SPAN, 50000, extra pulse width at full scale
- RAMP_STEP, 4, maximum speed change per channel per frame (must be ≥1)

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Target  in  CHANNELS*SPEED_W  packed target speeds; channel i occupies bits [i*SPEED_W +: SPEED_W]
- TargetValid  in  1  Target word offered
- TargetReady  out  1  pending slot empty; a word is accepted when Valid && Ready
- Stop  in  1  level; emergency stop to neutral, bypassing the ramp
- PWM  out  CHANNELS  servo pulse outputs
- Current  out  CHANNELS*SPEED_W  ramped speed currently driving each channel
- FrameStart  out  1  one-cycle pulse at each frame boundary
- Settled  out  1  all Current == target, and pending slot empty

## Operation
- Frame counter runs 0..PERIOD_CYCLES-1 and wraps. The cycle with count 0 is the frame boundary (FB), and FrameStart is high in that cycle.
- One-entry pending register:
  - Accept on Valid && Ready; Ready is deasserted while the slot is full.
  - At FB, the pending word moves to target and the slot empties.
  - A word offered on an FB cycle while the slot is full is not accepted (Ready = 0). The master holds Valid.
- Ramp at each FB, per channel, using d = target − cur after the pending transfer:
  - cur += d if |d| ≤ RAMP_STEP, else cur += sign(d)·RAMP_STEP.
  - Arithmetic is SPEED_W+1 bits signed, so there is no wrap.
  - The update order within one FB is: pending→target, then ramp, then threshold latch.
- Threshold: thr = MIN_PULSE + ((cur·PULSE_SPAN) >> SPEED_W).
  - It is latched at FB from the updated cur and held constant for the whole frame. There are no glitches mid-frame.
  - The intermediate product width is SPEED_W + clog2(PULSE_SPAN+1).
- PWM[i] is high for exactly thr_i cycles per frame. Requirement: MIN_PULSE + PULSE_SPAN < PERIOD_CYCLES.
- Stop:
  - While asserted, pending is cleared, Ready = 0 and target = neutral.
  - At the next FB, cur = neutral directly with no ramp.
  - After Stop deasserts, Ready returns the next cycle.
- Settled is combinational from registered state.

## Timing
- Reset values (in effect the cycle after Reset is sampled high):
  - counter 0, cur = target = neutral, pending empty.
  - PWM = 0, FrameStart = 0, TargetReady = 0, Settled = 1.
- First cycle after Reset deasserts: count = 0, so FrameStart = 1 and TargetReady = 1.
- FrameStart in cycle T → PWM high in cycles T+1 .. T+thr (registered compare, one cycle of latency).
- Accept-to-effect latency: a word accepted in cycle A affects the PWM of the first frame whose FB is after A.
- Reset mid-frame aborts the frame. PWM goes low the next cycle and the pending word is discarded.
- Reset has priority over Stop; Stop has priority over TargetValid.
- Current updates in the FB cycle and is visible the cycle after.

## Structure
- Shared package servo_pkg holds:
  - direction codes (Forward, Backward, LForward, RForward, LBackward, RBackward, idle), so the navigation controller maps directions to speed words.
  - a neutral-speed constant function of SPEED_W.
  - a pulse-threshold function.
- Sub-module servo_pwm_channel (generated CHANNELS times): ramp register, threshold latch, PWM compare.
- The top level owns the frame counter, the pending/handshake logic and the Stop logic.

## Test plan
Bench parameters: PERIOD_CYCLES=100, MIN_PULSE=10, PULSE_SPAN=20, SPEED_W=8, RAMP_STEP=16, CHANNELS=2.
- Reset, no commands → both PWM high 20 cycles per 100, Current = 128/128, Settled = 1, first FrameStart the cycle after Reset deasserts.
- Target {255, 0} accepted mid-frame:
  - channel 0 Current goes 144, 160 … 240, 255; it reaches 255 at the 8th FB, with thr = 29.
  - channel 1 reaches 0 at the 8th FB, with thr = 10.
  - Settled = 1 only after that FB.
- Two back-to-back Valid words in one frame → first accepted, Ready = 0 until the next FB, second accepted the cycle after that FB. Neither word is lost or duplicated.
- Stop asserted while channel 0 is ramping at 200 → Ready = 0 and pending dropped immediately; Current = 128 at the next FB with no intermediate steps.
- Reset asserted at count 15, while PWM is high → PWM = 0 the next cycle, pending discarded, Current = 128; normal frames resume with FrameStart the cycle after Reset releases.
- Target {130, 128} from neutral → a single step: Current 130 at the first FB (|d| ≤ RAMP_STEP); thr = 20 for both channels (10 + (130·20)>>8).

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp driver and its clients: direction
// codes for the navigation controller, neutral speed and pulse-width helpers.
package servo_pkg;

   // Direction codes the navigation controller maps onto speed words
   typedef enum logic [2:0] {
      DIR_IDLE,
      DIR_FORWARD,
      DIR_BACKWARD,
      DIR_LFORWARD,
      DIR_RFORWARD,
      DIR_LBACKWARD,
      DIR_RBACKWARD
   } dir_e;

   // Stop speed: mid-scale of an unsigned speed word
   function automatic logic [31:0] neutral_speed(input int speed_w);
      return 32'd1 << (speed_w - 1);
   endfunction

   // High time of one frame in clocks for a given speed
   function automatic logic [31:0] pulse_thr(input logic [31:0] cur,
                                             input logic [31:0] min_pulse,
                                             input logic [31:0] span,
                                             input int          speed_w);
      logic [63:0] prod;
      prod = {32'd0, cur} * {32'd0, span};
      return min_pulse + 32'(prod >> speed_w);
   endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: slew-limited speed register, per-frame threshold latch
// and registered PWM compare against the shared frame counter.
module servo_pwm_channel
   import servo_pkg::*;
#(
   parameter int SPEED_W    = 8,
   parameter int MIN_PULSE  = 50000,
   parameter int PULSE_SPAN = 50000,
   parameter int RAMP_STEP  = 4,
   parameter int CNT_W      = 20
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_fb,
   input  logic               i_force_neutral,
   input  logic [SPEED_W-1:0] i_target,
   input  logic [CNT_W-1:0]   i_count,
   output logic [SPEED_W-1:0] o_current,
   output logic               o_pwm
);
   localparam int PROD_W = SPEED_W + $clog2(PULSE_SPAN + 1);
   localparam logic [SPEED_W-1:0] NEUTRAL = SPEED_W'(neutral_speed(SPEED_W));
   localparam logic signed [SPEED_W:0] STEP = $signed((SPEED_W+1)'(RAMP_STEP));
   localparam logic [CNT_W-1:0] THR_RST =
      CNT_W'(pulse_thr(32'(NEUTRAL), 32'(MIN_PULSE), 32'(PULSE_SPAN), SPEED_W));

   logic [SPEED_W-1:0]        r_cur;
   logic [CNT_W-1:0]          r_thr;
   logic                      r_pwm;
   logic signed [SPEED_W:0]   w_diff;
   logic signed [SPEED_W:0]   w_step;
   logic signed [SPEED_W:0]   w_sum;
   logic [SPEED_W-1:0]        w_cur_upd;
   logic [PROD_W-1:0]         w_prod;
   logic [CNT_W-1:0]          w_thr_new;
   logic [CNT_W-1:0]          w_thr_eff;

   // Next speed (clamped step, or neutral on stop) and the threshold it implies
   always_comb begin
      w_diff = $signed({1'b0, i_target}) - $signed({1'b0, r_cur});
      w_step = w_diff;
      if (w_diff > STEP)
         w_step = STEP;
      else if (w_diff < -STEP)
         w_step = -STEP;
      w_sum     = $signed({1'b0, r_cur}) + w_step;
      w_cur_upd = i_force_neutral ? NEUTRAL : SPEED_W'(w_sum);
      w_prod    = PROD_W'(w_cur_upd) * PROD_W'(PULSE_SPAN);
      w_thr_new = CNT_W'(32'(MIN_PULSE) + 32'(w_prod >> SPEED_W));
      // The frame-boundary compare must already see the new threshold
      w_thr_eff = i_fb ? w_thr_new : r_thr;
   end

   // Speed and threshold change only at the frame boundary; PWM is the
   // registered compare so the pulse occupies counts 1..thr
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cur <= NEUTRAL;
         r_thr <= THR_RST;
         r_pwm <= 1'b0;
      end else begin
         if (i_fb) begin
            r_cur <= w_cur_upd;
            r_thr <= w_thr_new;
         end
         r_pwm <= (i_count < w_thr_eff);
      end
   end

   assign o_current = r_cur;
   assign o_pwm     = r_pwm;

endmodule

// File: rtl/servo_ramp_driver.sv
// Multi-channel servo driver: frame counter, one-entry command slot with
// valid/ready handshake, emergency stop, and one ramp/PWM channel per servo.
module servo_ramp_driver
   import servo_pkg::*;
#(
   parameter int CHANNELS      = 2,
   parameter int SPEED_W       = 8,
   parameter int PERIOD_CYCLES = 1000000,
   parameter int MIN_PULSE     = 50000,
   parameter int PULSE_SPAN    = 50000,
   parameter int RAMP_STEP     = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [CHANNELS*SPEED_W-1:0]  i_target,
   input  logic                         i_target_valid,
   output logic                         o_target_ready,
   input  logic                         i_stop,
   output logic [CHANNELS-1:0]          o_pwm,
   output logic [CHANNELS*SPEED_W-1:0]  o_current,
   output logic                         o_frame_start,
   output logic                         o_settled
);
   localparam int CNT_W = $clog2(PERIOD_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [SPEED_W-1:0] NEUTRAL = SPEED_W'(neutral_speed(SPEED_W));
   localparam logic [CHANNELS*SPEED_W-1:0] NEUTRAL_VEC = {CHANNELS{NEUTRAL}};

   logic [CNT_W-1:0]              r_count;
   logic [CHANNELS*SPEED_W-1:0]   r_pending;
   logic [CHANNELS*SPEED_W-1:0]   r_target;
   logic                          r_full;
   logic                          r_stop_pend;
   logic                          w_fb;
   logic                          w_accept;
   logic                          w_force;
   logic [CHANNELS*SPEED_W-1:0]   w_tgt_eff;

   assign w_fb           = (r_count == '0) && !i_rst;
   assign o_frame_start  = w_fb;
   assign o_target_ready = !r_full && !i_stop && !i_rst;
   assign w_accept       = i_target_valid && o_target_ready;
   // Ramp sees the pending word in the same boundary it moves to target
   assign w_tgt_eff      = (w_fb && r_full) ? r_pending : r_target;
   // A stop seen anywhere in the frame snaps speeds at the next boundary
   assign w_force        = i_stop || r_stop_pend;
   assign o_settled      = (o_current == r_target) && !r_full;

   // Free-running frame counter, held at zero during reset
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_count <= '0;
      else if (r_count == LAST)
         r_count <= '0;
      else
         r_count <= r_count + 1'b1;
   end

   // Command slot, target register and stop memory
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full      <= 1'b0;
         r_pending   <= NEUTRAL_VEC;
         r_target    <= NEUTRAL_VEC;
         r_stop_pend <= 1'b0;
      end else if (i_stop) begin
         r_full      <= 1'b0;
         r_target    <= NEUTRAL_VEC;
         // At a boundary the stop acts directly; remember it only otherwise
         r_stop_pend <= !w_fb;
      end else begin
         if (w_fb) begin
            r_stop_pend <= 1'b0;
            if (r_full)
               r_target <= r_pending;
         end
         if (w_accept) begin
            r_pending <= i_target;
            r_full    <= 1'b1;
         end else if (w_fb) begin
            r_full    <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      servo_pwm_channel #(
         .SPEED_W    (SPEED_W),
         .MIN_PULSE  (MIN_PULSE),
         .PULSE_SPAN (PULSE_SPAN),
         .RAMP_STEP  (RAMP_STEP),
         .CNT_W      (CNT_W)
      ) u_ch (
         .i_clk           (i_clk),
         .i_rst           (i_rst),
         .i_fb            (w_fb),
         .i_force_neutral (w_force),
         .i_target        (w_tgt_eff[g*SPEED_W +: SPEED_W]),
         .i_count         (r_count),
         .o_current       (o_current[g*SPEED_W +: SPEED_W]),
         .o_pwm           (o_pwm[g])
      );
   end

endmodule

// File: tb/tb_servo_ramp_driver.sv
// Directed bench for servo_ramp_driver with a short 100-clock frame.
module tb_servo_ramp_driver;
   localparam int CH = 2, SW = 8, PER = 100, MINP = 10, SPAN = 20, STEP = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            valid = 1'b0;
   logic            stop = 1'b0;
   logic [CH*SW-1:0] tgt = '0;
   logic            ready, fs, settled;
   logic [CH-1:0]   pwm;
   logic [CH*SW-1:0] cur;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   servo_ramp_driver #(
      .CHANNELS(CH), .SPEED_W(SW), .PERIOD_CYCLES(PER),
      .MIN_PULSE(MINP), .PULSE_SPAN(SPAN), .RAMP_STEP(STEP)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_target(tgt), .i_target_valid(valid),
      .o_target_ready(ready), .i_stop(stop), .o_pwm(pwm), .o_current(cur),
      .o_frame_start(fs), .o_settled(settled)
   );

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wait_fb();
      int n = 0;
      do begin cyc(); n++; end while (!fs && n < 200);
      n_cmp++;
      if (fs !== 1'b1) begin n_err++; $display("FAIL fb_timeout: no FrameStart within %0d cycles", n); end
   endtask

   // Counts high cycles per channel and FrameStarts over the next 100 cycles
   task automatic measure(output int h0, output int h1, output int nfs);
      h0 = 0; h1 = 0; nfs = 0;
      for (int i = 0; i < PER; i++) begin
         cyc();
         h0 += int'(pwm[0]);
         h1 += int'(pwm[1]);
         nfs += int'(fs);
      end
   endtask

   task automatic test_reset();
      int h0, h1, nfs;
      logic [CH-1:0] p1;
      rst = 1'b1;
      repeat (3) cyc();
      n_cmp++; if (pwm !== 2'b00) begin n_err++; $display("FAIL rst_pwm: got %b want 00", pwm); end
      n_cmp++; if (fs !== 1'b0) begin n_err++; $display("FAIL rst_fs: got %b want 0", fs); end
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ready); end
      n_cmp++; if (settled !== 1'b1) begin n_err++; $display("FAIL rst_settled: got %b want 1", settled); end
      n_cmp++; if (cur !== 16'h8080) begin n_err++; $display("FAIL rst_cur: got %h want 8080", cur); end
      rst = 1'b0; #1;
      n_cmp++; if (fs !== 1'b1) begin n_err++; $display("FAIL first_fs: got %b want 1", fs); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL first_ready: got %b want 1", ready); end
      cyc(); p1 = pwm;
      n_cmp++; if (p1 !== 2'b11) begin n_err++; $display("FAIL pwm_latency: got %b want 11", p1); end
      repeat (4) cyc();
      measure(h0, h1, nfs);
      n_cmp++; if (h0 != 20 || h1 != 20) begin n_err++; $display("FAIL neutral_width: got %0d/%0d want 20/20", h0, h1); end
      n_cmp++; if (nfs != 1) begin n_err++; $display("FAIL fs_per_frame: got %0d want 1", nfs); end
   endtask

   task automatic test_ramp();
      int e0[8] = '{144, 160, 176, 192, 208, 224, 240, 255};
      int e1[8] = '{112, 96, 80, 64, 48, 32, 16, 0};
      logic [CH*SW-1:0] exp_cur;
      int h0, h1, nfs;
      repeat (30) cyc();
      tgt = {8'd0, 8'd255}; valid = 1'b1; #1;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL ramp_accept: got %b want 1", ready); end
      cyc(); valid = 1'b0;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ramp_full: got %b want 0", ready); end
      n_cmp++; if (settled !== 1'b0) begin n_err++; $display("FAIL ramp_pending_settled: got %b want 0", settled); end
      for (int k = 0; k < 8; k++) begin
         wait_fb(); cyc();
         exp_cur = {8'(e1[k]), 8'(e0[k])};
         n_cmp++; if (cur !== exp_cur) begin n_err++; $display("FAIL ramp_cur[%0d]: got %h want %h", k, cur, exp_cur); end
         n_cmp++; if (settled !== (k == 7)) begin n_err++; $display("FAIL ramp_settled[%0d]: got %b want %b", k, settled, k == 7); end
      end
      measure(h0, h1, nfs);
      n_cmp++; if (h0 != 29 || h1 != 10) begin n_err++; $display("FAIL ramp_width: got %0d/%0d want 29/10", h0, h1); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int bad = 0;
      repeat (10) cyc();
      tgt = {8'd8, 8'd250}; valid = 1'b1; #1;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_first_ready: got %b want 1", ready); end
      cyc(); tgt = {8'd20, 8'd240}; #1;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_blocked: got %b want 0", ready); end
      while (!fs && n < 200) begin
         cyc(); n++;
         if (ready !== 1'b0) bad++;
      end
      n_cmp++; if (fs !== 1'b1) begin n_err++; $display("FAIL b2b_fb_timeout: got %b want 1", fs); end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_ready_low: got %0d high cycles want 0", bad); end
      cyc();
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_fb: got %b want 1", ready); end
      n_cmp++; if (cur !== {8'd8, 8'd250}) begin n_err++; $display("FAIL b2b_cur_a: got %h want 08fa", cur); end
      cyc(); valid = 1'b0;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_taken: got %b want 0", ready); end
      wait_fb(); cyc();
      n_cmp++; if (cur !== {8'd20, 8'd240}) begin n_err++; $display("FAIL b2b_cur_b: got %h want 14f0", cur); end
      n_cmp++; if (settled !== 1'b1 || ready !== 1'b1) begin n_err++; $display("FAIL b2b_done: got settled %b ready %b want 1 1", settled, ready); end
   endtask

   task automatic test_stop();
      int e0[3] = '{224, 208, 200};
      int e1[3] = '{36, 52, 68};
      logic [CH*SW-1:0] exp_cur;
      repeat (5) cyc();
      tgt = {8'd128, 8'd200}; valid = 1'b1;
      cyc(); valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_fb(); cyc();
         exp_cur = {8'(e1[k]), 8'(e0[k])};
         n_cmp++; if (cur !== exp_cur) begin n_err++; $display("FAIL stop_pre_cur[%0d]: got %h want %h", k, cur, exp_cur); end
      end
      repeat (20) cyc();
      tgt = {8'd0, 8'd0}; valid = 1'b1;
      cyc(); valid = 1'b0;
      stop = 1'b1;
      repeat (4) cyc();
      n_cmp++; if (cur !== {8'd68, 8'd200}) begin n_err++; $display("FAIL stop_midframe_cur: got %h want 44c8", cur); end
      stop = 1'b0;
      cyc();
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL stop_pending_dropped: got ready %b want 1", ready); end
      stop = 1'b1; #1;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL stop_ready_immediate: got %b want 0", ready); end
      stop = 1'b0;
      wait_fb(); cyc();
      n_cmp++; if (cur !== 16'h8080) begin n_err++; $display("FAIL stop_snap: got %h want 8080", cur); end
      wait_fb(); cyc();
      n_cmp++; if (cur !== 16'h8080 || settled !== 1'b1) begin n_err++; $display("FAIL stop_hold: got %h settled %b want 8080 1", cur, settled); end
   endtask

   task automatic test_reset_mid();
      int h0, h1, nfs;
      wait_fb();
      repeat (5) cyc();
      tgt = {8'd200, 8'd200}; valid = 1'b1; #1;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rmid_accept: got %b want 1", ready); end
      cyc(); valid = 1'b0;
      repeat (9) cyc();
      n_cmp++; if (pwm !== 2'b11) begin n_err++; $display("FAIL rmid_pwm_high: got %b want 11", pwm); end
      rst = 1'b1;
      cyc();
      n_cmp++; if (pwm !== 2'b00) begin n_err++; $display("FAIL rmid_pwm_abort: got %b want 00", pwm); end
      n_cmp++; if (cur !== 16'h8080) begin n_err++; $display("FAIL rmid_cur: got %h want 8080", cur); end
      n_cmp++; if (ready !== 1'b0 || fs !== 1'b0) begin n_err++; $display("FAIL rmid_flags: got ready %b fs %b want 0 0", ready, fs); end
      rst = 1'b0; #1;
      n_cmp++; if (fs !== 1'b1) begin n_err++; $display("FAIL rmid_fs_resume: got %b want 1", fs); end
      cyc();
      n_cmp++; if (cur !== 16'h8080 || settled !== 1'b1) begin n_err++; $display("FAIL rmid_discard: got %h settled %b want 8080 1", cur, settled); end
      measure(h0, h1, nfs);
      n_cmp++; if (h0 != 20 || h1 != 20 || nfs != 1) begin n_err++; $display("FAIL rmid_frame: got %0d/%0d fs %0d want 20/20 fs 1", h0, h1, nfs); end
   endtask

   task automatic test_small_step();
      int h0, h1, nfs;
      repeat (10) cyc();
      tgt = {8'd128, 8'd130}; valid = 1'b1; #1;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL small_accept: got %b want 1", ready); end
      cyc(); valid = 1'b0;
      wait_fb(); cyc();
      n_cmp++; if (cur !== {8'd128, 8'd130}) begin n_err++; $display("FAIL small_cur: got %h want 8082", cur); end
      n_cmp++; if (settled !== 1'b1) begin n_err++; $display("FAIL small_settled: got %b want 1", settled); end
      measure(h0, h1, nfs);
      n_cmp++; if (h0 != 20 || h1 != 20) begin n_err++; $display("FAIL small_width: got %0d/%0d want 20/20", h0, h1); end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_back_to_back();
      test_stop();
      test_reset_mid();
      test_small_step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
